aes_v2_mix_size: RTL and testbench

Lightweight AES MixColumns instruction unit, optimised for small size. It sits directly downstream of the size-optimised SubBytes unit and consumes the same interleaved two-register byte layout that unit produces. One shared GF(2^8) row-multiplier evaluates one output byte per cycle, and three intermediate bytes are kept in registers. A 4-cycle FSM produces one 32-bit column result per operation, forward (encrypt) or inverse (decrypt).

---
 rtl/aes_v2_mix_size.sv | 84 ++++++++
 tb/tb_aes_v2_mix_size.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/aes_v2_mix_size.sv
// AES MixColumns / InvMixColumns unit: one shared GF(2^8) row evaluator,
// one output byte per cycle, a 32-bit column result after four valid cycles.
module aes_v2_mix_size (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] rd
);

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    logic [1:0]      fsm;
    logic [1:0]      fsm_next;
    logic [7:0]      b0, b1, b2;
    logic [3:0][7:0] col;
    logic [3:0][7:0] rot;
    logic [7:0]      r_out;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] row(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d,
                                       input logic fwd);
        logic [7:0] a2, a4, a8, b2x, b4, b8, c2, c4, c8, d2, d4, d8;
        a2 = xtime(a); a4 = xtime(a2); a8 = xtime(a4);
        b2x = xtime(b); b4 = xtime(b2x); b8 = xtime(b4);
        c2 = xtime(c); c4 = xtime(c2); c8 = xtime(c4);
        d2 = xtime(d); d4 = xtime(d2); d8 = xtime(d4);
        if (fwd)
            return a2 ^ b2x ^ b ^ c ^ d;
        // 0e*a ^ 0b*b ^ 0d*c ^ 09*d
        return (a8 ^ a4 ^ a2) ^ (b8 ^ b2x ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
    endfunction

    // Interleaved layout from the SubBytes unit: even bytes in rs1, odd in rs2.
    assign col = {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]};

    always_comb begin
        case (fsm)
            S1:      rot = {col[0], col[3], col[2], col[1]};
            S2:      rot = {col[1], col[0], col[3], col[2]};
            S3:      rot = {col[2], col[1], col[0], col[3]};
            default: rot = col;
        endcase
        rot = rot & {32{valid}};
    end

    assign r_out = row(rot[0], rot[1], rot[2], rot[3], enc);

    // S3 + 1 wraps to S0, giving back-to-back operations; dropping valid aborts.
    assign fsm_next = valid ? fsm + 2'd1 : S0;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fsm <= S0;
            b0  <= 8'h00;
            b1  <= 8'h00;
            b2  <= 8'h00;
        end else begin
            fsm <= fsm_next;
            if (valid) begin
                case (fsm)
                    S0:      b0 <= r_out;
                    S1:      b1 <= r_out;
                    S2:      b2 <= r_out;
                    default: ;
                endcase
            end
        end
    end

    assign ready = valid && (fsm == S3);
    assign rd    = ready ? {r_out, b2, b1, b0} : 32'h0;

endmodule

// File: tb/tb_aes_v2_mix_size.sv
// Directed and randomized bench for aes_v2_mix_size against a GF(2^8) matrix model.
module tb_aes_v2_mix_size;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready;
    logic [31:0] rd;

    int errors = 0;
    int checks = 0;

    aes_v2_mix_size dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .valid    (valid),
        .rs1      (rs1),
        .rs2      (rs2),
        .enc      (enc),
        .ready    (ready),
        .rd       (rd)
    );

    always #5 g_clk = ~g_clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product: o_i = sum_j coef[(j - i) mod 4] * c_j
    function automatic logic [31:0] mix(input logic [3:0][7:0] c, input logic fwd);
        logic [3:0][7:0] coef;
        logic [31:0] res = 32'h0;
        logic [7:0] acc;
        coef = fwd ? {8'h01, 8'h01, 8'h03, 8'h02} : {8'h09, 8'h0d, 8'h0b, 8'h0e};
        for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
                acc = acc ^ gmul(coef[(j - i + 4) % 4], c[j]);
            res[8*i +: 8] = acc;
        end
        return res;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle (entered just after a rising edge), check at the falling edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic e, input logic exp_rdy, input logic [31:0] exp_rd,
                        input string tag);
        valid = v; rs1 = a; rs2 = b; enc = e;
        @(negedge g_clk);
        chk1({tag, ".ready"}, ready, exp_rdy);
        chk32({tag, ".rd"}, rd, exp_rd);
        @(posedge g_clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic e,
                          input logic [31:0] exp_rd, input string tag);
        for (int k = 0; k < 3; k++) step(1'b1, a, b, e, 1'b0, 32'h0, tag);
        step(1'b1, a, b, e, 1'b1, exp_rd, tag);
    endtask

    initial begin
        logic [3:0][7:0] c;
        logic            e;
        logic [31:0]     a, b, exp_rd;

        g_resetn = 1'b0;
        valid = 1'b0; rs1 = 32'h0; rs2 = 32'h0; enc = 1'b0;
        @(posedge g_clk);
        valid = 1'b1; rs1 = 32'h005300db; rs2 = 32'h45001300; enc = 1'b1;
        @(negedge g_clk);
        chk1("reset.ready", ready, 1'b0);
        chk32("reset.rd", rd, 32'h0);
        @(posedge g_clk);
        #1;
        valid = 1'b0;
        g_resetn = 1'b1;

        run_op(32'h005300db, 32'h45001300, 1'b1, 32'hbca14d8e, "fwd_db");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "idle");
        run_op(32'h00a1008e, 32'hbc004d00, 1'b0, 32'h455313db, "inv_rt");

        run_op(32'h002200f2, 32'h5c000a00, 1'b1, 32'h9d58dc9f, "b2b_f2");
        run_op(32'h00c600c6, 32'hc600c600, 1'b0, 32'hc6c6c6c6, "b2b_c6");

        step(1'b1, 32'h005300db, 32'h45001300, 1'b1, 1'b0, 32'h0, "abort_pre");
        step(1'b1, 32'h005300db, 32'h45001300, 1'b1, 1'b0, 32'h0, "abort_pre");
        step(1'b0, 32'h005300db, 32'h45001300, 1'b1, 1'b0, 32'h0, "abort_gap");
        run_op(32'h005300db, 32'h45001300, 1'b1, 32'hbca14d8e, "abort_restart");

        // Reset while in S2
        step(1'b1, 32'h005300db, 32'h45001300, 1'b1, 1'b0, 32'h0, "rst_s2_pre");
        step(1'b1, 32'h005300db, 32'h45001300, 1'b1, 1'b0, 32'h0, "rst_s2_pre");
        #2 g_resetn = 1'b0;
        #1;
        chk1("rst_s2.ready", ready, 1'b0);
        chk32("rst_s2.rd", rd, 32'h0);
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        run_op(32'h005300db, 32'h45001300, 1'b1, 32'hbca14d8e, "rst_s2_after");

        // Reset while in S3 with valid high: ready must drop immediately
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h00a1008e, 32'hbc004d00, 1'b0, 1'b0, 32'h0, "rst_s3_pre");
        #2 g_resetn = 1'b0;
        #1;
        chk1("rst_s3.ready", ready, 1'b0);
        chk32("rst_s3.rd", rd, 32'h0);
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        run_op(32'h00a1008e, 32'hbc004d00, 1'b0, 32'h455313db, "rst_s3_after");

        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 4; i++) c[i] = 8'($urandom);
            e = 1'($urandom);
            a = {8'($urandom), c[2], 8'($urandom), c[0]};
            b = {c[3], 8'($urandom), c[1], 8'($urandom)};
            exp_rd = mix(c, e);
            run_op(a, b, e, exp_rd, "rand");
            if ($urandom_range(0, 7) == 0)
                step(1'b0, a, b, e, 1'b0, 32'h0, "rand_gap");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
